cook_sequencer: RTL and testbench

Cooking-cycle sequencer for the microwave datapath. It sits between the front-panel buttons, the door switch and the countdown timer. It decides when the timer counts, when the magnetron is energised and at what duty cycle (power level), and it produces the end-of-cycle beep. It replaces the bare start/stop latch with a four-state controller that supports pause/resume, cancel and a 1–10 power level.

---
 rtl/cook_sequencer_if.sv | 43 ++++
 rtl/cook_sequencer.sv | 157 +++++++++++++++
 tb/tb_cook_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cook_sequencer_if.sv
// ---------------------------------------------------------------------------
// cook_sequencer_if
// Groups the panel/door/timer signals exchanged between the cooking-cycle
// sequencer and the rest of the microwave datapath.
//   slave  modport : the sequencer (consumes buttons, door, timer status;
//                    drives timer control, magnetron, buzzer, state)
//   master modport : the surrounding datapath / front panel
// Signals:
//   tick         1 Hz one-clock enable pulse (same pulse as the timer uses)
//   startn       start button, active-low, synchronised
//   stopn        stop/cancel button, active-low, synchronised
//   door_closed  1 = door closed
//   timer_done   timer reads 00:00 (level)
//   power_level  requested power 1..10
//   timer_enable timer counts on tick while 1
//   timer_clear  one-cycle pulse zeroing the timer
//   mag_on       magnetron drive
//   beep         buzzer drive
//   state        IDLE=0, COOK=1, PAUSED=2, DONE=3
// ---------------------------------------------------------------------------
interface cook_sequencer_if;
  logic       tick;
  logic       startn;
  logic       stopn;
  logic       door_closed;
  logic       timer_done;
  logic [3:0] power_level;
  logic       timer_enable;
  logic       timer_clear;
  logic       mag_on;
  logic       beep;
  logic [1:0] state;

  modport slave (
    input  tick, startn, stopn, door_closed, timer_done, power_level,
    output timer_enable, timer_clear, mag_on, beep, state
  );

  modport master (
    output tick, startn, stopn, door_closed, timer_done, power_level,
    input  timer_enable, timer_clear, mag_on, beep, state
  );
endinterface

// File: rtl/cook_sequencer.sv
// ---------------------------------------------------------------------------
// cook_sequencer
// Four-state cooking-cycle controller (IDLE/COOK/PAUSED/DONE). Decides when
// the countdown timer runs, gates the magnetron with a power-level duty
// window, and sounds the end-of-cycle beep.
// Ports:
//   clock  system clock, rising edge
//   clear  asynchronous active-high reset
//   bus    cook_sequencer_if.slave (buttons, door, timer, power in;
//          timer_enable, timer_clear, mag_on, beep, state out)
// Parameters:
//   DUTY_PERIOD  ticks per power duty window
//   BEEP_TICKS   ticks the done beep lasts
// ---------------------------------------------------------------------------
module cook_sequencer #(
  parameter int DUTY_PERIOD = 10,
  parameter int BEEP_TICKS  = 3
) (
  input  logic           clock,
  input  logic           clear,
  cook_sequencer_if.slave bus
);

  localparam int DW = (DUTY_PERIOD > 1) ? $clog2(DUTY_PERIOD) : 1;
  localparam int BW = (BEEP_TICKS > 0) ? $clog2(BEEP_TICKS + 1) : 1;
  // Common width for the duty-vs-power compare.
  localparam int CW = (DW > 4) ? DW : 4;

  localparam logic [DW-1:0] DUTY_LAST = DW'(DUTY_PERIOD - 1);
  localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COOK   = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          startn_q, stopn_q;
  logic [3:0]    pwr_q, pwr_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          mag_q, mag_d;
  logic          ten_q, ten_d;
  logic          tclr_q, tclr_d;
  logic          beep_q, beep_d;

  logic start_ev, stop_ev;

  // Out-of-range requests (0 or above 10) run at full power.
  function automatic logic [3:0] sat_power(input logic [3:0] p);
    return ((p == 4'd0) || (p > 4'd10)) ? 4'd10 : p;
  endfunction

  // Falling-edge detect: a held button yields a single event.
  assign start_ev = startn_q & ~bus.startn;
  assign stop_ev  = stopn_q  & ~bus.stopn;

  always_comb begin
    state_d    = state_q;
    pwr_d      = pwr_q;
    duty_d     = duty_q;
    beep_cnt_d = beep_cnt_q;
    tclr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (stop_ev) begin
          tclr_d = 1'b1;
        end else if (start_ev && bus.door_closed && !bus.timer_done) begin
          state_d = COOK;
          pwr_d   = sat_power(bus.power_level);
          duty_d  = '0;
        end
      end

      COOK: begin
        if (bus.tick) begin
          duty_d = (duty_q == DUTY_LAST) ? '0 : duty_q + DW'(1);
        end
        // End of cycle outranks a coincident door open or stop.
        if (bus.timer_done) begin
          state_d    = DONE;
          beep_cnt_d = BEEP_LOAD;
        end else if (!bus.door_closed || stop_ev) begin
          state_d = PAUSED;
        end
      end

      PAUSED: begin
        if (stop_ev) begin
          state_d = IDLE;
          tclr_d  = 1'b1;
        end else if (bus.timer_done) begin
          state_d = IDLE;
        end else if (start_ev && bus.door_closed) begin
          state_d = COOK;
        end
      end

      DONE: begin
        if (stop_ev) begin
          state_d = IDLE;
        end else if (bus.tick) begin
          if (beep_cnt_q <= BW'(1)) begin
            beep_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            beep_cnt_d = beep_cnt_q - BW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Output drives are registered decodes of the current state.
    ten_d  = (state_q == COOK);
    beep_d = (state_q == DONE);
    mag_d  = (state_q == COOK) && (CW'(duty_q) < CW'(pwr_q));
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      startn_q   <= 1'b1;
      stopn_q    <= 1'b1;
      pwr_q      <= 4'd10;
      duty_q     <= '0;
      beep_cnt_q <= '0;
      mag_q      <= 1'b0;
      ten_q      <= 1'b0;
      tclr_q     <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      startn_q   <= bus.startn;
      stopn_q    <= bus.stopn;
      pwr_q      <= pwr_d;
      duty_q     <= duty_d;
      beep_cnt_q <= beep_cnt_d;
      mag_q      <= mag_d;
      ten_q      <= ten_d;
      tclr_q     <= tclr_d;
      beep_q     <= beep_d;
    end
  end

  // Door interlock acts combinationally so drive dies the instant it opens.
  assign bus.mag_on       = mag_q & bus.door_closed;
  assign bus.timer_enable = ten_q;
  assign bus.timer_clear  = tclr_q;
  assign bus.beep         = beep_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cook_sequencer
// Directed bench for cook_sequencer: drives the panel, door and timer-status
// inputs step by step and checks the outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_cook_sequencer;

  logic clock;
  logic clear;
  int   vectors;
  int   miscompares;
  int   on_cnt;

  cook_sequencer_if bus ();

  cook_sequencer #(
    .DUTY_PERIOD(10),
    .BEEP_TICKS (3)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick_step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    on_cnt      = 0;
    clear           = 1'b1;
    bus.tick        = 1'b0;
    bus.startn      = 1'b1;
    bus.stopn       = 1'b1;
    bus.door_closed = 1'b1;
    bus.timer_done  = 1'b0;
    bus.power_level = 4'd10;
    step(2);

    // Reset state
    chk_s("rst_state", bus.state, 2'd0);
    chk_b("rst_ten",   bus.timer_enable, 1'b0);
    chk_b("rst_mag",   bus.mag_on, 1'b0);
    chk_b("rst_beep",  bus.beep, 1'b0);
    chk_b("rst_tclr",  bus.timer_clear, 1'b0);
    clear = 1'b0;
    step();

    // Full-power run, 5 s
    bus.startn = 1'b0;
    step();
    chk_s("full_state_cook", bus.state, 2'd1);
    chk_b("full_ten_lat1", bus.timer_enable, 1'b0);
    bus.startn = 1'b1;
    step();
    chk_b("full_ten_lat2", bus.timer_enable, 1'b1);
    chk_b("full_mag_start", bus.mag_on, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick_step();
      chk_b("full_mag_tick", bus.mag_on, 1'b1);
      step();
    end
    bus.timer_done = 1'b1;
    step();
    chk_s("full_state_done", bus.state, 2'd3);
    step();
    chk_b("full_beep_on", bus.beep, 1'b1);
    chk_b("full_ten_off", bus.timer_enable, 1'b0);
    chk_b("full_mag_off", bus.mag_on, 1'b0);
    tick_step();
    chk_s("beep_tick1", bus.state, 2'd3);
    step();
    tick_step();
    chk_s("beep_tick2", bus.state, 2'd3);
    step();
    tick_step();
    chk_s("beep_tick3_idle", bus.state, 2'd0);
    chk_b("beep_last", bus.beep, 1'b1);
    step();
    chk_b("beep_off", bus.beep, 1'b0);
    bus.timer_done = 1'b0;
    step();

    // Half power, 20 s
    bus.power_level = 4'd5;
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      chk_b("half_mag", bus.mag_on, ((k % 10) < 5));
      if (bus.mag_on) on_cnt++;
      tick_step();
      step();
    end
    chk_i("half_on_count", on_cnt, 10);

    // Cancel: stop from COOK, then stop again
    bus.stopn = 1'b0;
    step();
    chk_s("cancel_paused", bus.state, 2'd2);
    chk_b("cancel_no_clr", bus.timer_clear, 1'b0);
    bus.stopn = 1'b1;
    step();
    chk_b("cancel_ten_off", bus.timer_enable, 1'b0);
    bus.stopn = 1'b0;
    step();
    chk_s("cancel_idle", bus.state, 2'd0);
    chk_b("cancel_clr_on", bus.timer_clear, 1'b1);
    bus.stopn = 1'b1;
    step();
    chk_b("cancel_clr_off", bus.timer_clear, 1'b0);

    // Door open mid-cook at power 5, resume keeps duty and power
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      tick_step();
      step();
    end
    bus.door_closed = 1'b0;
    #1;
    chk_b("door_mag_instant", bus.mag_on, 1'b0);
    step();
    chk_s("door_paused", bus.state, 2'd2);
    chk_b("door_ten_lat1", bus.timer_enable, 1'b1);
    step();
    chk_b("door_ten_lat2", bus.timer_enable, 1'b0);
    bus.power_level = 4'd10;
    tick_step();
    bus.door_closed = 1'b1;
    step();
    chk_b("door_closed_paused_mag", bus.mag_on, 1'b0);
    bus.startn = 1'b0;
    step();
    chk_s("resume_cook", bus.state, 2'd1);
    bus.startn = 1'b1;
    step();
    chk_b("resume_mag_d3", bus.mag_on, 1'b1);
    tick_step();
    step();
    chk_b("resume_mag_d4", bus.mag_on, 1'b1);
    tick_step();
    step();
    chk_b("resume_mag_d5", bus.mag_on, 1'b0);

    // Start and stop together from PAUSED
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
    step();
    chk_s("both_pre_paused", bus.state, 2'd2);
    bus.startn = 1'b0;
    bus.stopn  = 1'b0;
    step();
    chk_s("both_idle", bus.state, 2'd0);
    chk_b("both_clr", bus.timer_clear, 1'b1);
    bus.startn = 1'b1;
    bus.stopn  = 1'b1;
    step();

    // Start with door open, and start with timer at zero, from IDLE
    bus.door_closed = 1'b0;
    bus.startn = 1'b0;
    step();
    chk_s("door_open_start", bus.state, 2'd0);
    bus.startn = 1'b1;
    step();
    bus.door_closed = 1'b1;
    bus.timer_done = 1'b1;
    bus.startn = 1'b0;
    step();
    chk_s("timer_zero_start", bus.state, 2'd0);
    bus.startn = 1'b1;
    bus.timer_done = 1'b0;
    step();

    // Start held low for 100 cycles
    bus.startn = 1'b0;
    step();
    chk_s("held_cook", bus.state, 2'd1);
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
    step(98);
    chk_s("held_single_event", bus.state, 2'd2);
    bus.startn = 1'b1;
    step();
    chk_s("held_release", bus.state, 2'd2);
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
    step();

    // Power level 0 behaves as 10
    bus.power_level = 4'd0;
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step();
    chk_b("pwr0_mag_d0", bus.mag_on, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick_step();
      step();
    end
    chk_b("pwr0_mag_d9", bus.mag_on, 1'b1);
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
    step();
    bus.stopn = 1'b0;
    step();
    bus.stopn = 1'b1;
    step();

    // Power level 13 behaves as 10
    bus.power_level = 4'd13;
    bus.startn = 1'b0;
    step();
    bus.startn = 1'b1;
    step();
    chk_b("pwr13_mag", bus.mag_on, 1'b1);

    // Reset mid-COOK
    chk_b("pre_rst_ten", bus.timer_enable, 1'b1);
    clear = 1'b1;
    #1;
    chk_b("rst_cook_mag", bus.mag_on, 1'b0);
    chk_b("rst_cook_ten", bus.timer_enable, 1'b0);
    chk_s("rst_cook_state", bus.state, 2'd0);
    step();
    clear = 1'b0;
    step();
    bus.power_level = 4'd10;
    bus.startn = 1'b0;
    step();
    chk_s("post_rst_cook", bus.state, 2'd1);
    bus.startn = 1'b1;
    step();
    chk_b("post_rst_ten", bus.timer_enable, 1'b1);

    // Reset during DONE kills the beep
    bus.timer_done = 1'b1;
    step();
    chk_s("done_again", bus.state, 2'd3);
    step();
    chk_b("done_beep", bus.beep, 1'b1);
    clear = 1'b1;
    #1;
    chk_b("rst_done_beep", bus.beep, 1'b0);
    chk_s("rst_done_state", bus.state, 2'd0);
    step();
    clear = 1'b0;
    bus.timer_done = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
